// File: rtl/udp_rx_pkg.sv
// Shared types and helpers for the UDP receive packet buffer.
package udp_rx_pkg;

  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_DATA  = 2'd2
  } rd_state_t;

  // Byte-keep of the final word, keyed by the two low bits of the frame length.
  function automatic logic [3:0] keep_for_len(input logic [1:0] len_lo);
    case (len_lo)
      2'd1:    return 4'b1000;
      2'd2:    return 4'b1100;
      2'd3:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  // Number of 32-bit words needed to hold a byte count; 17 bits so 16'hFFFF+3 cannot wrap.
  function automatic logic [16:0] words_for_bytes(input logic [15:0] bytes);
    return ({1'b0, bytes} + 17'd3) >> 2;
  endfunction

endpackage

// File: rtl/udp_rx_pkt_buf_ram.sv
// Simple dual-port payload RAM: one write port, one registered read port.
module udp_rx_buf_ram
  import udp_rx_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = WORD_W
) (
  input  logic              sys_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port and one-cycle-latency read port; the reader never targets a word being written.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_rx_pkt_buf.sv
// Frame buffer between the UDP parser and the application stream.
// Frames are written speculatively and either committed (descriptor pushed)
// or discarded by rewinding wr_ptr to commit_ptr.
//
// Read FSM states:
//   state    | meaning
//   RD_IDLE  | waiting for a committed frame descriptor
//   RD_FETCH | RAM read in flight, data lands next edge
//   RD_DATA  | word presented on the stream, holding until handshake
module udp_rx_pkt_buf
  import udp_rx_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int LEN_AW = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        in_data_en,
  input  logic [31:0] in_data,
  input  logic        in_end,
  input  logic [15:0] in_byte_num,
  input  logic        in_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [3:0]  out_keep,
  output logic [15:0] out_len,
  output logic [15:0] drop_cnt
);

  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PTR_FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LEN_AW:0] DESC_ONE  = {{LEN_AW{1'b0}}, 1'b1};
  localparam logic [LEN_AW:0] DESC_FULL = {1'b1, {LEN_AW{1'b0}}};

  logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr, rd_ptr_n, used, wr_ptr_inc;
  logic [16:0]     frame_wcnt, eff_wcnt, exp_wcnt;
  logic            frame_err, frame_ovf;
  logic            buf_full, wr_word, wr_ovf, frame_drop, desc_push, desc_pop;

  logic [15:0]     desc_mem [2**LEN_AW];
  logic [LEN_AW:0] desc_wr_ptr, desc_rd_ptr, desc_used;
  logic            desc_full, desc_empty;
  logic [15:0]     desc_head;

  rd_state_t       rd_state, rd_state_n;
  logic [16:0]     words_left, words_left_n;
  logic            out_valid_n, out_last_n;
  logic [3:0]      out_keep_n;
  logic [31:0]     out_data_n, ram_rd_data;
  logic [15:0]     out_len_n;
  logic            ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;

  assign used       = wr_ptr - rd_ptr;
  assign buf_full   = (used == PTR_FULL);
  assign wr_word    = in_data_en && !buf_full;
  assign wr_ovf     = in_data_en && buf_full;
  assign wr_ptr_inc = wr_word ? (wr_ptr + PTR_ONE) : wr_ptr;
  assign eff_wcnt   = frame_wcnt + {16'd0, wr_word};
  assign exp_wcnt   = words_for_bytes(in_byte_num);

  assign desc_used  = desc_wr_ptr - desc_rd_ptr;
  assign desc_full  = (desc_used == DESC_FULL);
  assign desc_empty = (desc_wr_ptr == desc_rd_ptr);
  assign desc_head  = desc_mem[desc_rd_ptr[LEN_AW-1:0]];

  // A word lost to overflow in the end cycle also fails the count check, but flag it directly.
  assign frame_drop = frame_err || in_err || frame_ovf || wr_ovf || desc_full ||
                      (in_byte_num == 16'd0) || (eff_wcnt != exp_wcnt);
  assign desc_push  = in_end && !frame_drop;

  udp_rx_buf_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_ram (
    .sys_clk (sys_clk),
    .wr_en   (wr_word && !sys_rst),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (in_data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // Write side: speculative frame fill, commit or rewind on frame end, drop counting.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      frame_wcnt  <= '0;
      frame_err   <= 1'b0;
      frame_ovf   <= 1'b0;
      drop_cnt    <= '0;
      desc_wr_ptr <= '0;
    end else if (in_end) begin
      frame_wcnt <= '0;
      frame_err  <= 1'b0;
      frame_ovf  <= 1'b0;
      if (frame_drop) begin
        wr_ptr <= commit_ptr;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else begin
        wr_ptr      <= wr_ptr_inc;
        commit_ptr  <= wr_ptr_inc;
        desc_wr_ptr <= desc_wr_ptr + DESC_ONE;
      end
    end else begin
      wr_ptr     <= wr_ptr_inc;
      frame_wcnt <= eff_wcnt;
      if (in_err) frame_err <= 1'b1;
      if (wr_ovf) frame_ovf <= 1'b1;
    end
  end

  // Descriptor storage; contents need no reset since the pointers define validity.
  always_ff @(posedge sys_clk) begin
    if (desc_push && !sys_rst) desc_mem[desc_wr_ptr[LEN_AW-1:0]] <= in_byte_num;
  end

  // Read FSM next-state and registered-output next values.
  always_comb begin
    rd_state_n   = rd_state;
    rd_ptr_n     = rd_ptr;
    words_left_n = words_left;
    out_valid_n  = out_valid;
    out_last_n   = out_last;
    out_keep_n   = out_keep;
    out_data_n   = out_data;
    out_len_n    = out_len;
    desc_pop     = 1'b0;
    ram_rd_en    = 1'b0;
    ram_rd_addr  = rd_ptr[ADDR_W-1:0];
    case (rd_state)
      RD_IDLE: begin
        if (!desc_empty) begin
          desc_pop     = 1'b1;
          out_len_n    = desc_head;
          words_left_n = words_for_bytes(desc_head);
          ram_rd_en    = 1'b1;
          rd_state_n   = RD_FETCH;
        end
      end
      RD_FETCH: begin
        out_data_n  = ram_rd_data;
        out_valid_n = 1'b1;
        out_last_n  = (words_left == 17'd1);
        out_keep_n  = (words_left == 17'd1) ? keep_for_len(out_len[1:0]) : 4'b1111;
        rd_state_n  = RD_DATA;
      end
      RD_DATA: begin
        if (out_ready) begin
          rd_ptr_n     = rd_ptr + PTR_ONE;
          words_left_n = words_left - 17'd1;
          out_valid_n  = 1'b0;
          out_last_n   = 1'b0;
          out_keep_n   = 4'b0000;
          if (out_last) begin
            out_len_n  = 16'd0;
            rd_state_n = RD_IDLE;
          end else begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = rd_ptr_n[ADDR_W-1:0];
            rd_state_n  = RD_FETCH;
          end
        end
      end
      default: rd_state_n = RD_IDLE;
    endcase
  end

  // Read FSM state and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_state    <= RD_IDLE;
      rd_ptr      <= '0;
      words_left  <= '0;
      desc_rd_ptr <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_keep    <= 4'b0000;
      out_data    <= '0;
      out_len     <= '0;
    end else begin
      rd_state   <= rd_state_n;
      rd_ptr     <= rd_ptr_n;
      words_left <= words_left_n;
      out_valid  <= out_valid_n;
      out_last   <= out_last_n;
      out_keep   <= out_keep_n;
      out_data   <= out_data_n;
      out_len    <= out_len_n;
      if (desc_pop) desc_rd_ptr <= desc_rd_ptr + DESC_ONE;
    end
  end

endmodule

// File: tb/tb_udp_rx_pkt_buf.sv
// Self-checking bench for udp_rx_pkt_buf with a 16-word payload RAM.
module tb_udp_rx_pkt_buf;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic        sys_clk, sys_rst;
  logic        in_data_en, in_end, in_err;
  logic [31:0] in_data;
  logic [15:0] in_byte_num;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic [15:0] out_len, drop_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [15:0] len;
  } beat_t;

  beat_t       got_q[$];
  beat_t       exp_q[$];
  logic [31:0] tx_words[$];
  int total = 0;
  int bad = 0;
  int exp_drop = 0;
  int stall_err = 0;
  int rdy_mode = 1;

  udp_rx_pkt_buf #(.ADDR_W(ADDR_W), .LEN_AW(4)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .in_data_en  (in_data_en),
    .in_data     (in_data),
    .in_end      (in_end),
    .in_byte_num (in_byte_num),
    .in_err      (in_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_keep    (out_keep),
    .out_len     (out_len),
    .drop_cnt    (drop_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Consumer ready pattern.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = ~out_ready;
      endcase
    end
  end

  // Beat collector and hold-under-stall monitor, sampled mid-cycle.
  initial begin
    beat_t cur, prev;
    bit prev_stall;
    prev_stall = 0;
    prev = '0;
    forever begin
      @(negedge sys_clk);
      cur.data = out_data; cur.keep = out_keep; cur.last = out_last; cur.len = out_len;
      if (sys_rst) prev_stall = 0;
      else begin
        if (prev_stall && (out_valid !== 1'b1 || cur !== prev)) stall_err++;
        if (out_valid && out_ready) got_q.push_back(cur);
        prev_stall = out_valid && !out_ready;
        prev = cur;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic clear_in();
    in_data_en = 0; in_data = '0; in_end = 0; in_byte_num = '0; in_err = 0;
  endtask

  // Drives tx_words as one frame; err_idx<0 means no error pulse.
  task automatic drive_frame(input int bytes, input int err_idx, input bit end_sep, input int max_gap);
    int n;
    n = tx_words.size();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      in_data_en = 1; in_data = tx_words[i]; in_err = (i == err_idx);
      if (i == n - 1 && !end_sep) begin in_end = 1; in_byte_num = 16'(bytes); end
      tick();
      clear_in();
    end
    if (end_sep || n == 0) begin
      in_end = 1; in_byte_num = 16'(bytes);
      tick();
      clear_in();
    end
  endtask

  // Expected stream for an accepted frame: every byte of tx_words up to 'bytes'.
  task automatic model_frame(input int bytes);
    beat_t b;
    int nb;
    for (int i = 0; i < tx_words.size(); i++) begin
      nb = bytes - 4 * i;
      b.data = tx_words[i];
      b.last = (nb <= 4);
      b.keep = (nb >= 4) ? 4'hF : 4'(4'hF << (4 - nb));
      b.len  = 16'(bytes);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin tick(); c++; end
    repeat (6) tick();
  endtask

  task automatic fill_random(input int n);
    tx_words.delete();
    for (int i = 0; i < n; i++) tx_words.push_back($urandom);
  endtask

  task automatic test_reset();
    clear_in();
    sys_rst = 1;
    repeat (3) tick();
    sys_rst = 0;
    @(negedge sys_clk);
    total++;
    if ({out_valid, out_last, out_data, out_keep, out_len} !== '0) begin
      bad++; $display("FAIL reset_outputs got v=%b l=%b d=%h k=%b len=%0d exp all zero", out_valid, out_last, out_data, out_keep, out_len);
    end
    total++;
    if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_len8();
    got_q.delete(); exp_q.delete(); rdy_mode = 1;
    tx_words = '{32'h01020304, 32'h05060708};
    drive_frame(8, -1, 0, 0);
    model_frame(8);
    wait_beats(2, 200);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL len8_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL len8_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (drop_cnt !== exp_drop[15:0]) begin bad++; $display("FAIL len8_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
  endtask

  task automatic test_partial5();
    got_q.delete(); exp_q.delete(); rdy_mode = 1;
    tx_words = '{32'hAABBCCDD, 32'hEE000000};
    drive_frame(5, -1, 0, 1);
    model_frame(5);
    wait_beats(2, 200);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL len5_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL len5_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_err_drop();
    got_q.delete(); exp_q.delete(); rdy_mode = 1;
    fill_random(3);
    drive_frame(12, 1, 0, 0);
    exp_drop++;
    tx_words = '{32'hCAFEF00D};
    drive_frame(4, -1, 0, 0);
    model_frame(4);
    wait_beats(1, 200);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL err_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL err_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (drop_cnt !== exp_drop[15:0]) begin bad++; $display("FAIL err_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
  endtask

  task automatic test_overflow();
    got_q.delete(); exp_q.delete(); rdy_mode = 0;
    fill_random(10);
    drive_frame(40, -1, 0, 0);
    model_frame(40);
    fill_random(10);
    drive_frame(40, -1, 0, 0);
    exp_drop++;
    repeat (5) tick();
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL ovf_stalled got=%0d beats exp=0", got_q.size()); end
    total++;
    if (drop_cnt !== exp_drop[15:0]) begin bad++; $display("FAIL ovf_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
    rdy_mode = 1;
    wait_beats(10, 300);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    fill_random(1);
    drive_frame(3, -1, 0, 0);
    model_frame(3);
    wait_beats(1, 200);
    total++;
    if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL ovf_after got=%0d beats exp=1 matching", got_q.size());
    end
  endtask

  task automatic test_mismatch_backpressure();
    got_q.delete(); exp_q.delete(); stall_err = 0; rdy_mode = 1;
    fill_random(2);
    drive_frame(12, -1, 0, 0);
    exp_drop++;
    repeat (4) tick();
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL mism_output got=%0d beats exp=0", got_q.size()); end
    total++;
    if (drop_cnt !== exp_drop[15:0]) begin bad++; $display("FAIL mism_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
    rdy_mode = 3;
    fill_random(7);
    drive_frame(26, -1, 1, 2);
    model_frame(26);
    wait_beats(7, 400);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (stall_err != 0) begin bad++; $display("FAIL bp_hold got=%0d unstable stalls exp=0", stall_err); end
  endtask

  task automatic test_reset_mid();
    int c;
    got_q.delete(); exp_q.delete(); rdy_mode = 0;
    fill_random(2);
    drive_frame(8, -1, 0, 0);
    c = 0;
    while (out_valid !== 1'b1 && c < 50) begin tick(); c++; end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%b exp=1", out_valid); end
    in_data_en = 1; in_data = $urandom;
    tick();
    clear_in();
    sys_rst = 1;
    tick();
    sys_rst = 0;
    @(negedge sys_clk);
    total++;
    if ({out_valid, out_last, out_data, out_keep, out_len} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs got v=%b l=%b d=%h k=%b len=%0d exp all zero", out_valid, out_last, out_data, out_keep, out_len);
    end
    total++;
    if (drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_drop got=%0d exp=0", drop_cnt); end
    exp_drop = 0;
    got_q.delete(); exp_q.delete(); rdy_mode = 1;
    tx_words = '{32'h11223344, 32'h55667788};
    drive_frame(8, -1, 0, 0);
    model_frame(8);
    wait_beats(2, 200);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rst_after_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rst_after_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // One frame at a time with a drained buffer, so acceptance follows directly from the frame rules.
  task automatic test_random();
    int n, kind, bytes, err_idx;
    bit accept;
    stall_err = 0; rdy_mode = 2;
    for (int f = 0; f < 25; f++) begin
      got_q.delete(); exp_q.delete();
      n = $urandom_range(1, DEPTH + 3);
      kind = $urandom_range(0, 7);
      bytes = 4 * (n - 1) + $urandom_range(1, 4);
      if (kind == 1) bytes += 4;
      if (kind == 2) bytes = 0;
      err_idx = (kind == 0) ? $urandom_range(0, n - 1) : -1;
      accept = (kind >= 3) && (n <= DEPTH);
      fill_random(n);
      drive_frame(bytes, err_idx, ($urandom_range(0, 1) == 1), 3);
      if (accept) model_frame(bytes);
      else exp_drop++;
      wait_beats(exp_q.size(), 400);
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", f, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_beat%0d got=%h exp=%h", f, i, got_q[i], exp_q[i]); end
      end
      total++;
      if (drop_cnt !== exp_drop[15:0]) begin bad++; $display("FAIL rnd%0d_drop got=%0d exp=%0d", f, drop_cnt, exp_drop); end
    end
    total++;
    if (stall_err != 0) begin bad++; $display("FAIL rnd_hold got=%0d unstable stalls exp=0", stall_err); end
  endtask

  initial begin
    sys_rst = 1;
    clear_in();
    test_reset();
    test_len8();
    test_partial5();
    test_err_drop();
    test_overflow();
    test_mismatch_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_rx_pkt_buf.md
Name: udp_rx_pkt_buf

Overview:
Downstream stage of the UDP receive parser. It accepts the parser's 32-bit payload words, per-frame end strobe, byte count and error flag, and buffers each frame in a word RAM. Good frames are committed; frames with errors, overflow or bad length are discarded by rewinding the write pointer. Committed frames are replayed to the application on a valid/ready stream with last and byte-keep markers.

Parameters:
ADDR_W, 9, log2 of payload RAM depth in 32-bit words (default 512 words = 2 KB)
LEN_AW, 4, log2 of length-descriptor FIFO depth (default 16 frames)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
in_data_en  in  1  payload word strobe from the parser
in_data  in  32  payload word; first byte in [31:24]
in_end  in  1  frame end pulse; may coincide with the final in_data_en
in_byte_num  in  16  frame payload byte count; valid when in_end=1
in_err  in  1  parser error flag (level or pulse)
out_valid  out  1  output word valid
out_ready  in  1  consumer ready
out_data  out  32  output word, same byte order as in_data
out_last  out  1  final word of the frame
out_keep  out  4  valid bytes; bit3 = [31:24]
out_len  out  16  frame byte count; stable for the whole frame while out_valid=1
drop_cnt  out  16  dropped-frame counter, saturating at 16'hFFFF

Behaviour:
- One clock (sys_clk). Reset is synchronous and active-high on sys_rst. It clears all pointers, the descriptor FIFO, the error and overflow latches and drop_cnt. It forces out_valid, out_last, out_data, out_keep and out_len to 0 and the read FSM to RD_IDLE. Reset mid-frame discards the partial frame and all uncommitted and committed data.
- Pointers are ADDR_W+1 bits: wr_ptr, commit_ptr and rd_ptr. used = wr_ptr - rd_ptr. Full means used == 2^ADDR_W.
- Write side, when in_data_en=1:
  - If not full: mem[wr_ptr] <= in_data, wr_ptr++, frame_wcnt++.
  - If full: the word is discarded and frame_ovf is set.
- frame_err is set on any cycle with in_err=1. It clears only when in_end is processed, or on reset.
- in_end processing uses the effective word count: frame_wcnt, plus 1 if a word is written in the same cycle.
  - Drop if any of: frame_err, in_err, frame_ovf, descriptor FIFO full, in_byte_num==0, or effective count != (in_byte_num+3)>>2 computed at 17 bits.
  - On drop: wr_ptr <= commit_ptr and drop_cnt++ (saturating).
  - Otherwise commit: commit_ptr <= wr_ptr (including the same-cycle word) and in_byte_num is pushed into the descriptor FIFO.
  - In both cases frame_wcnt, frame_err and frame_ovf clear. If in_data_en is asserted in the same cycle, the next frame's first word is not mixed in: in_end always terminates the current frame.
- Read FSM:
  - RD_IDLE: if the descriptor FIFO is non-empty, pop it into out_len. Set words_left = (len+3)>>2 and issue a RAM read at rd_ptr. Go to RD_FETCH.
  - RD_FETCH: RAM data arrives with 1-cycle latency. Register out_data, set out_valid=1, out_last=(words_left==1), and set out_keep. Go to RD_DATA.
  - RD_DATA: hold all outputs stable while out_valid && !out_ready. On a handshake: rd_ptr++ and words_left--.
    - If out_last: out_valid=0, out_len=0, go to RD_IDLE.
    - Otherwise: out_valid=0, issue the next read, go to RD_FETCH.
- Throughput is 1 word per 2 clocks. This exceeds the MII input rate of 1 word per 8 clocks.
- out_keep is 4'b1111 on non-last words. On the last word it is keyed by len[1:0]: 0→1111, 1→1000, 2→1100, 3→1110. Unused bytes in a partial word carry don't-care data.
- Reads and writes proceed concurrently. Uncommitted words are never visible to the reader, because the reader relies only on descriptors.
- Free-space check uses rd_ptr, so space is reclaimed only after words are handshaken.

Decomposition:
- Package udp_rx_pkg: read state typedef (RD_IDLE, RD_FETCH, RD_DATA), KEEP lookup function for len[1:0], and a word-count function ceil(bytes/4).
- Sub-module udp_rx_buf_ram: simple dual-port RAM with one write port and one synchronously registered read port, parameterised by ADDR_W and width 32.
- The descriptor FIFO (16-bit × 2^LEN_AW) is coded inline.

Test Plan:
1. 8-byte frame: words 0x01020304, 0x05060708, in_end with the 2nd word, in_byte_num=8, out_ready=1 → two beats: keep 1111/1111, out_last on beat 2, out_len=8, drop_cnt=0.
2. 5-byte frame: words 0xAABBCCDD, 0xEE000000, in_byte_num=5 → beat 2 has keep 1000, out_last=1, out_len=5.
3. in_err pulse mid-frame on a 12-byte frame, then a clean 4-byte frame 0xCAFEF00D → only 0xCAFEF00D is output (keep 1111, last), drop_cnt=1.
4. ADDR_W=4, out_ready=0, two 40-byte frames (10 words each) → second frame dropped on overflow, drop_cnt=1. Then raise out_ready → exactly 10 words of frame 1 are output, and afterwards a new frame is accepted.
5. Length mismatch: 2 words with in_byte_num=12 → no output, drop_cnt=1. Backpressure on a good frame with out_ready toggling every cycle → out_data, out_keep and out_last are stable while valid && !ready, and no word is lost or duplicated.
6. Assert sys_rst for 1 cycle mid-frame and while out_valid=1 → next cycle all outputs are 0 and drop_cnt=0. A following 8-byte frame is output correctly.
